// File: rtl/mux2x1_arbiter_pkg.sv
// Shared encodings for the 2:1 mux arbiter: FSM states and mux select values.
// The select values match the s input of the downstream mux2x1 datapath.
package mux2x1_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_e;

    localparam logic SEL_A0 = 1'b0;
    localparam logic SEL_A1 = 1'b1;

    // Select value that routes requester idx through the mux.
    function automatic logic sel_for(input logic idx);
        return idx ? SEL_A1 : SEL_A0;
    endfunction

endpackage

// File: rtl/mux2x1_arbiter_stall_counter.sv
// Saturating stall counter for the arbiter's forced-release timeout.
// hit flags the stall cycle in which the count reaches MAX.
module stall_counter
    import mux2x1_arbiter_pkg::*;
#(
    parameter int unsigned MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic hit
);

    localparam int unsigned CW = $clog2(MAX + 1);
    localparam logic [CW-1:0] MAX_C  = CW'(MAX);
    localparam logic [CW-1:0] LAST_C = CW'(MAX - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX_C)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // hit must not look at clr: clr is derived from the arbiter's next state,
    // which itself depends on hit.
    assign hit = inc && (cnt_q >= LAST_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux2x1_arbiter.sv
// Round-robin, packet-locking arbiter driving the select of a 2:1 datapath mux.
// The grant is held from a requester's first beat until its last beat transfers.
module mux2x1_arbiter
    import mux2x1_arbiter_pkg::*;
#(
    parameter logic        PRIO_INIT = 1'b0,
    parameter int unsigned TIMEOUT   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       last0,
    input  logic       req1,
    input  logic       last1,
    input  logic       ready_in,
    output logic       gnt0,
    output logic       gnt1,
    output logic       rdy0,
    output logic       rdy1,
    output logic       valid_out,
    output logic       s,
    output logic       timeout,
    output logic [1:0] dbg_state,
    output logic       dbg_ptr
);

    // Handshake: reqN is the requester's valid for its current beat and
    // rdyN is the ready back to it. A beat transfers in any cycle where
    // reqN & rdyN are both high; req may drop between beats without
    // losing the grant, and lastN is only meaningful while reqN is high.

    arb_state_e state_q, state_d;
    logic       ptr_q, ptr_d;
    logic       s_q, s_d;
    logic       gnt0_q, gnt0_d;
    logic       gnt1_q, gnt1_d;
    logic       timeout_q, timeout_d;
    logic       xfer0, xfer1;
    logic       stall_hit;

    assign xfer0 = gnt0_q && req0 && ready_in;
    assign xfer1 = gnt1_q && req1 && ready_in;

    generate
        if (TIMEOUT > 0) begin : g_stall
            logic stall_clr;
            logic stall_inc;

            assign stall_inc = (gnt0_q || gnt1_q) && !(xfer0 || xfer1);
            assign stall_clr = (state_q == ST_IDLE) || xfer0 || xfer1
                               || (state_d != state_q);

            stall_counter #(
                .MAX (TIMEOUT)
            ) u_stall_counter (
                .clk (clk),
                .rst (rst),
                .clr (stall_clr),
                .inc (stall_inc),
                .hit (stall_hit)
            );
        end else begin : g_no_stall
            assign stall_hit = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0 && req1) begin
                    state_d = ptr_q ? ST_GNT1 : ST_GNT0;
                end else if (req0) begin
                    state_d = ST_GNT0;
                end else if (req1) begin
                    state_d = ST_GNT1;
                end
            end
            ST_GNT0: begin
                // A forced release behaves exactly like a last-beat transfer.
                if ((xfer0 && last0) || stall_hit) begin
                    ptr_d     = 1'b1;
                    timeout_d = stall_hit;
                    state_d   = req1 ? ST_GNT1 : ST_IDLE;
                end
            end
            ST_GNT1: begin
                if ((xfer1 && last1) || stall_hit) begin
                    ptr_d     = 1'b0;
                    timeout_d = stall_hit;
                    state_d   = req0 ? ST_GNT0 : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        gnt0_d = (state_d == ST_GNT0);
        gnt1_d = (state_d == ST_GNT1);
        s_d    = s_q;
        if (state_d == ST_GNT0) begin
            s_d = sel_for(1'b0);
        end else if (state_d == ST_GNT1) begin
            s_d = sel_for(1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= PRIO_INIT;
            s_q       <= SEL_A0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            s_q       <= s_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign rdy0      = gnt0_q && ready_in;
    assign rdy1      = gnt1_q && ready_in;
    assign valid_out = (gnt0_q && req0) || (gnt1_q && req1);
    assign s         = s_q;
    assign timeout   = timeout_q;
    assign dbg_state = state_q;
    assign dbg_ptr   = ptr_q;

endmodule
